// File: rtl/matrix_panel_pkg.sv
// Shared definitions for the scrolling LED matrix panel: the 2-bit mode
// encoding used on the mode input and throughout the panel logic.
package matrix_panel_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_STATIC   = 2'b01,
        MODE_SCROLL_L = 2'b10,
        MODE_SCROLL_R = 2'b11
    } mode_t;

endpackage

// File: rtl/matrix_scan_timer.sv
// Scan timing for the LED matrix: a prescaler sets the column period, the
// column index walks across the matrix, and a frame counter divides frames
// down to scroll steps. "clear" parks everything at zero; "run" lets it count.
module matrix_scan_timer #(
    parameter int COLS            = 7,
    parameter int SCAN_DIV        = 50000,
    parameter int FRAMES_PER_STEP = 8,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clear,
    output logic [CW-1:0] col_idx,
    output logic          presc_zero,
    output logic          frame_tick,
    output logic          step
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_col_idx;
    logic [FW-1:0] r_frame_cnt;
    logic          r_frame_tick;

    logic w_presc_wrap;
    logic w_col_wrap;
    logic w_frame_wrap;

    // Wrap detection for each level of the counter chain.
    always_comb begin
        w_presc_wrap = (r_presc == PRESC_LAST);
        w_col_wrap   = w_presc_wrap && (r_col_idx == COL_LAST);
        w_frame_wrap = w_col_wrap && (r_frame_cnt == FRAME_LAST);
    end

    // Counter chain; the tick is registered so it lands with col_idx == 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_col_idx    <= '0;
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else if (clear) begin
            r_presc      <= '0;
            r_col_idx    <= '0;
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else if (run) begin
            r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
            if (w_presc_wrap) begin
                r_col_idx <= w_col_wrap ? '0 : r_col_idx + 1'b1;
            end
            if (w_col_wrap) begin
                r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
            end
            r_frame_tick <= w_col_wrap;
        end else begin
            r_frame_tick <= 1'b0;
        end
    end

    assign col_idx    = r_col_idx;
    assign presc_zero = (r_presc == '0);
    assign frame_tick = r_frame_tick;
    assign step       = run && !clear && w_frame_wrap;

endmodule

// File: rtl/matrix_scroll_panel.sv
// Scrolling LED matrix controller: a writable message buffer of MSG_LEN
// columns shown through a COLS-wide window that can stay put or scroll
// left/right, scanned one column at a time.
// Optional build macro MATRIX_SCROLL_PANEL_GHOST_BLANK_EN blanks the first
// cycle of every column to suppress ghosting.
module matrix_scroll_panel
    import matrix_panel_pkg::*;
#(
    parameter int ROWS            = 5,
    parameter int COLS            = 7,
    parameter int MSG_LEN         = 16,
    parameter int SCAN_DIV        = 50000,
    parameter int FRAMES_PER_STEP = 8,
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      mode,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [ROWS-1:0] wr_data,
    output logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            frame_tick
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);

    logic [ROWS-1:0] r_buf [MSG_LEN];
    logic [AW-1:0]   r_offset;
    logic [ROWS-1:0] r_row;
    logic [COLS-1:0] r_col;
    logic            r_frame_tick;

    mode_t           w_mode;
    logic            w_run;
    logic            w_clear;
    logic [CW-1:0]   w_col_idx;
    logic            w_presc_zero;
    logic            w_tick;
    logic            w_step;
    logic [AW-1:0]   w_rd_idx;

    // (offset + c) mod MSG_LEN with one carry bit, so no wrap is lost.
    function automatic logic [AW-1:0] buf_index(input logic [AW-1:0] off,
                                                input logic [CW-1:0] c);
        logic [AW:0] s;
        s = {1'b0, off} + (AW+1)'(c);
        if (s >= (AW+1)'(MSG_LEN)) begin
            s = s - (AW+1)'(MSG_LEN);
        end
        return s[AW-1:0];
    endfunction

    function automatic logic [COLS-1:0] onehot(input logic [CW-1:0] c);
        logic [COLS-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    assign w_mode   = mode_t'(mode);
    assign w_run    = (w_mode != MODE_OFF);
    assign w_clear  = (w_mode == MODE_OFF);
    assign w_rd_idx = buf_index(r_offset, w_col_idx);

    matrix_scan_timer #(
        .COLS            (COLS),
        .SCAN_DIV        (SCAN_DIV),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (w_run),
        .clear      (w_clear),
        .col_idx    (w_col_idx),
        .presc_zero (w_presc_zero),
        .frame_tick (w_tick),
        .step       (w_step)
    );

    // Message buffer: host writes accepted in every mode, bad addresses dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Window offset moves one column per scroll step; mode changes never reset it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_offset <= '0;
        end else if (w_step) begin
            case (w_mode)
                MODE_SCROLL_L: r_offset <= (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
                MODE_SCROLL_R: r_offset <= (r_offset == '0) ? OFF_LAST : r_offset - 1'b1;
                default:       r_offset <= r_offset;
            endcase
        end
    end

    // Registered drivers, one cycle behind the scan state and buffer contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_frame_tick <= 1'b0;
        end else if (w_mode == MODE_OFF) begin
            r_row        <= '0;
            r_col        <= '0;
            r_frame_tick <= 1'b0;
        end else begin
`ifdef MATRIX_SCROLL_PANEL_GHOST_BLANK_EN
            r_row <= w_presc_zero ? '0 : r_buf[w_rd_idx];
            r_col <= w_presc_zero ? '0 : onehot(w_col_idx);
`else
            r_row <= r_buf[w_rd_idx];
            r_col <= onehot(w_col_idx);
`endif
            r_frame_tick <= w_tick;
        end
    end

`ifndef MATRIX_SCROLL_PANEL_GHOST_BLANK_EN
    // Prescaler phase only matters when blanking is built in.
    logic w_unused;
    assign w_unused = w_presc_zero;
`endif

    assign row        = r_row;
    assign col        = r_col;
    assign frame_tick = r_frame_tick;

endmodule

// File: doc/matrix_scroll_panel.md
# matrix_scroll_panel

Parametrised successor to the fixed 5x7 LED panel controller. It holds a writable message buffer of `MSG_LEN` columns and multiplexes a `ROWS` x `COLS` LED matrix one column at a time. Modes are off, static, scroll-left and scroll-right, with programmable scan rate and scroll speed. It sits between the board switches / host write port and the matrix row/column drivers, replacing the hard-coded pattern registers, frequency divider, counter and decoder chain.

## Interface
Parameters:
- `ROWS`, default 5: matrix rows, which is also the bits per buffer column.
- `COLS`, default 7: matrix columns, scanned one at a time.
- `MSG_LEN`, default 16: buffer depth in columns. Constraint: `MSG_LEN >= COLS`.
- `SCAN_DIV`, default 50000: clk cycles per column. Constraint: `SCAN_DIV >= 2`.
- `FRAMES_PER_STEP`, default 8: full frames per one-column scroll step. Constraint: `>= 1`.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: 00 OFF, 01 STATIC, 10 SCROLL_L, 11 SCROLL_R.
- `wr_en`, in, 1: buffer write strobe.
- `wr_addr`, in, `$clog2(MSG_LEN)`: buffer column address. Addresses `>= MSG_LEN` are ignored.
- `wr_data`, in, `ROWS`: column pattern. Bit r drives row r.
- `row`, out, `ROWS`: row drive, active-high.
- `col`, out, `COLS`: column select, one-hot active-high, or all zero.
- `frame_tick`, out, 1: one-cycle pulse at each frame start.

## Operation
- Reset state:
  - buffer all zero;
  - `offset`, `presc`, `col_idx` and `frame_cnt` all 0;
  - `row`, `col` and `frame_tick` all 0.
- Scan:
  - `presc` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `col_idx` advances 0..COLS-1 and wraps.
  - On the `col_idx` wrap, `frame_cnt` advances 0..FRAMES_PER_STEP-1 and wraps, and `frame_tick` pulses.
- Display: the displayed column c shows `buf[(offset + c) mod MSG_LEN]`. The modulo is computed at full width, with no truncation.
- Outputs are registered every cycle: `col <= onehot(col_idx)`, `row <= buf[(offset+col_idx) mod MSG_LEN]`.
- Modes:
  - OFF: `row`/`col` forced 0. `presc`, `col_idx` and `frame_cnt` held at 0. `offset` held. Buffer writes still accepted.
  - STATIC: scan runs; `offset` frozen.
  - SCROLL_L: on each `frame_cnt` wrap, `offset <= (offset+1) mod MSG_LEN`; MSG_LEN-1 wraps to 0.
  - SCROLL_R: on each `frame_cnt` wrap, `offset <= (offset-1) mod MSG_LEN`; 0 wraps to MSG_LEN-1.
- Mode change:
  - takes effect at the next clk edge;
  - `offset` is never reset by a mode change;
  - a change into a scroll mode mid-frame waits for the next `frame_cnt` wrap;
  - OFF to any other mode restarts scan at column 0.
- Writes:
  - Buffer is written on `wr_en`.
  - Write and read of the same address in the same cycle: `row` shows the old data that cycle and the new data from the next cycle.
  - A write during an offset update is independent; both take effect.

## Timing
- Output latency: `row`/`col` lag `col_idx` and buffer contents by exactly 1 cycle.
- Column period: SCAN_DIV cycles.
- Frame period: COLS*SCAN_DIV cycles.
- Scroll step period: FRAMES_PER_STEP*COLS*SCAN_DIV cycles.
- `frame_tick`: high for exactly one cycle, in the cycle `col` first shows column 0 of a new frame. Never asserted in OFF.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously. Release is synchronous to the next clk edge.

## Configuration
- Macro: `MATRIX_SCROLL_PANEL_GHOST_BLANK_EN`.
- Defined:
  - `row` and `col` are forced 0 in the output cycle corresponding to `presc == 0`, giving one blank cycle per column against ghosting;
  - all periods are unchanged;
  - `frame_tick` timing is unchanged.
- Undefined: no blanking; each column is driven for all SCAN_DIV cycles.

## Structure
- Package `matrix_panel_pkg`:
  - mode encoding constants (MODE_OFF, MODE_STATIC, MODE_SCROLL_L, MODE_SCROLL_R);
  - the 2-bit mode typedef.
- Sub-module `matrix_scan_timer`:
  - owns `presc`, `col_idx`, `frame_cnt`;
  - produces `col_idx`, `frame_tick` and `step` (the `frame_cnt` wrap strobe);
  - has `run` and `clear` inputs driven by mode.
- Top level owns the buffer, `offset`, and the output registers.

## Test plan
All scenarios use ROWS=5, COLS=7, MSG_LEN=16, SCAN_DIV=4, FRAMES_PER_STEP=2, macro undefined unless stated.
- Reset, then mode OFF for 100 cycles -> `row`=0, `col`=0, `frame_tick` never high.
- Write addr0=5'b11111, addr1=5'b00001, then mode STATIC -> `col`=7'b0000001 with `row`=11111 for 4 cycles, then `col`=7'b0000010 with `row`=00001. `frame_tick` pulses every 28 cycles.
- Write addr0=5'b11111, then SCROLL_L -> after 56 cycles `offset`=1, and column 0 shows addr1. After 16 steps, `offset` wraps to 0.
- SCROLL_R from reset -> first step gives `offset`=15, and column 0 shows addr15.
- STATIC, write addr3=5'b10101 in the cycle `col_idx`=3 -> `row` shows old addr3 data that cycle and 10101 next cycle.
- Macro defined, STATIC -> each column gives 1 cycle of `row`/`col`=0, then 3 cycles driven. Frame is still 28 cycles.
